// File: rtl/fetch_ctrl_if.sv
// Request/control bundle between the hazard, branch and exception logic and the IF stage.
// The master side raises next-PC requests; the slave side (fetch_ctrl) drives the IF controls.
interface fetch_ctrl_if;
  logic        imem_ready;
  logic        ld_use;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        eret;

  logic        PcWrite;
  logic        pc_src;
  logic [31:0] address;
  logic        error;
  logic [31:0] error_address;
  logic        pc_flush;
  logic        if_lw;
  logic [31:0] epc;
  logic        in_handler;
  logic        exc_drop;
  logic        misalign;

  modport master (
    output imem_ready, ld_use, br_taken, br_target, exc_req, exc_pc, eret,
    input  PcWrite, pc_src, address, error, error_address, pc_flush, if_lw,
           epc, in_handler, exc_drop, misalign
  );

  modport slave (
    input  imem_ready, ld_use, br_taken, br_target, exc_req, exc_pc, eret,
    output PcWrite, pc_src, address, error, error_address, pc_flush, if_lw,
           epc, in_handler, exc_drop, misalign
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: arbitrates exception / eret / branch / load-use requests and holds EPC.
// Optional macro PC_ALIGN_CHK_EN traps misaligned branch targets as exceptions.
module fetch_ctrl #(
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_1000,
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter int unsigned LD_STALL_CYCLES = 1
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave fc
);

  localparam int unsigned CNT_MAX = (FLUSH_CYCLES > LD_STALL_CYCLES) ? FLUSH_CYCLES : LD_STALL_CYCLES;
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LD_STALL_CYCLES - 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      epc_q, epc_nxt;
  logic             inh_q, inh_nxt;

  logic        pc_write, pc_src, error, pc_flush, if_lw, exc_drop, misalign;
  logic [31:0] address;
  logic        redirect, mis_br;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    epc_nxt   = epc_q;
    inh_nxt   = inh_q;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    address   = '0;
    error     = 1'b0;
    pc_flush  = 1'b0;
    if_lw     = 1'b0;
    exc_drop  = 1'b0;
    misalign  = 1'b0;
    redirect  = 1'b0;
    mis_br    = 1'b0;
`ifdef PC_ALIGN_CHK_EN
    mis_br = fc.br_taken && (fc.br_target[1:0] != 2'b00);
`endif

    if (fc.exc_req && !inh_q) begin
      error    = 1'b1;
      epc_nxt  = fc.exc_pc;
      inh_nxt  = 1'b1;
      redirect = 1'b1;
    end else begin
      // A nested exception is dropped and the lower-priority requests still get their turn.
      exc_drop = fc.exc_req;
      if (fc.eret) begin
        pc_src   = 1'b1;
        address  = epc_q;
        inh_nxt  = 1'b0;
        redirect = 1'b1;
      end else if (mis_br && !inh_q) begin
        error    = 1'b1;
        misalign = 1'b1;
        epc_nxt  = fc.br_target;
        inh_nxt  = 1'b1;
        redirect = 1'b1;
      end else if (fc.br_taken && !mis_br) begin
        pc_src   = 1'b1;
        address  = fc.br_target;
        redirect = 1'b1;
      end else begin
        if (mis_br) exc_drop = 1'b1;
        unique case (state)
          RUN: begin
            if (fc.ld_use) begin
              if_lw     = 1'b1;
              cnt_nxt   = STALL_INIT;
              state_nxt = (LD_STALL_CYCLES > 1) ? STALL : RUN;
            end else begin
              pc_write = fc.imem_ready;
            end
          end
          STALL: begin
            if_lw   = 1'b1;
            cnt_nxt = sat_dec(cnt);
            if (cnt_nxt == '0) state_nxt = RUN;
          end
          FLUSH: begin
            // ld_use is ignored here: the instruction in ID is being squashed anyway.
            pc_flush = 1'b1;
            pc_write = fc.imem_ready;
            cnt_nxt  = sat_dec(cnt);
            if (cnt_nxt == '0) state_nxt = RUN;
          end
          default: state_nxt = RUN;
        endcase
      end
    end

    if (redirect) begin
      pc_write  = 1'b1;
      pc_flush  = 1'b1;
      cnt_nxt   = FLUSH_INIT;
      state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end

    // While reset is asserted IF is held squashed with the PC frozen.
    if (!reset) begin
      pc_write = 1'b0;
      pc_src   = 1'b0;
      address  = '0;
      error    = 1'b0;
      if_lw    = 1'b0;
      pc_flush = 1'b1;
      exc_drop = 1'b0;
      misalign = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
      epc_q <= '0;
      inh_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      epc_q <= epc_nxt;
      inh_q <= inh_nxt;
    end
  end

  assign fc.PcWrite       = pc_write;
  assign fc.pc_src        = pc_src;
  assign fc.address       = address;
  assign fc.error         = error;
  assign fc.error_address = EXC_VECTOR;
  assign fc.pc_flush      = pc_flush;
  assign fc.if_lw         = if_lw;
  assign fc.epc           = epc_q;
  assign fc.in_handler    = inh_q;
  assign fc.exc_drop      = exc_drop;
  assign fc.misalign      = misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed per-cycle vectors queue their expected outputs,
// an independent monitor compares them on the falling edge.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();

  fetch_ctrl #(
    .EXC_VECTOR     (32'h0000_1000),
    .FLUSH_CYCLES   (2),
    .LD_STALL_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fc   (bus)
  );

  typedef struct packed {
    logic        pcw;
    logic        src;
    logic [31:0] addr;
    logic        err;
    logic [31:0] err_addr;
    logic        flush;
    logic        lw;
    logic [31:0] epc;
    logic        inh;
    logic        drop;
    logic        mis;
  } outs_t;

  typedef struct {
    string name;
    outs_t exp;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic outs_t mk(input logic pcw, input logic src, input logic [31:0] addr,
                               input logic err, input logic flush, input logic lw,
                               input logic [31:0] epc, input logic inh, input logic drop,
                               input logic mis);
    outs_t o;
    o.pcw = pcw; o.src = src; o.addr = addr; o.err = err; o.err_addr = 32'h0000_1000;
    o.flush = flush; o.lw = lw; o.epc = epc; o.inh = inh; o.drop = drop; o.mis = mis;
    return o;
  endfunction

  task automatic cyc(input string name, input logic rst, input logic rdy, input logic ld,
                     input logic br, input logic [31:0] tgt, input logic exc,
                     input logic [31:0] xpc, input logic er, input outs_t e);
    item_t it;
    @(posedge clk);
    #1;
    reset = rst; bus.imem_ready = rdy; bus.ld_use = ld; bus.br_taken = br;
    bus.br_target = tgt; bus.exc_req = exc; bus.exc_pc = xpc; bus.eret = er;
    it.name = name;
    it.exp  = e;
    q.push_back(it);
  endtask

  // Monitor
  outs_t act;
  item_t cur;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
        act.pcw = bus.PcWrite; act.src = bus.pc_src; act.addr = bus.address;
        act.err = bus.error; act.err_addr = bus.error_address; act.flush = bus.pc_flush;
        act.lw = bus.if_lw; act.epc = bus.epc; act.inh = bus.in_handler;
        act.drop = bus.exc_drop; act.mis = bus.misalign;
        checks++;
        if (act !== cur.exp) begin
          errors++;
          $display("FAIL %s: got pcw=%b src=%b addr=%h err=%b eaddr=%h flush=%b lw=%b epc=%h inh=%b drop=%b mis=%b, expected pcw=%b src=%b addr=%h err=%b eaddr=%h flush=%b lw=%b epc=%h inh=%b drop=%b mis=%b",
                   cur.name, act.pcw, act.src, act.addr, act.err, act.err_addr, act.flush, act.lw,
                   act.epc, act.inh, act.drop, act.mis,
                   cur.exp.pcw, cur.exp.src, cur.exp.addr, cur.exp.err, cur.exp.err_addr,
                   cur.exp.flush, cur.exp.lw, cur.exp.epc, cur.exp.inh, cur.exp.drop, cur.exp.mis);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    outs_t R;
    R = mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0);
    reset = 1'b0; bus.imem_ready = 1'b1; bus.ld_use = 1'b0; bus.br_taken = 1'b0;
    bus.br_target = '0; bus.exc_req = 1'b0; bus.exc_pc = '0; bus.eret = 1'b0;

    // Reset and release
    cyc("rst0",        0, 1, 0, 0, 32'h0,   0, 32'h0,  0, R);
    cyc("rst1",        0, 1, 0, 0, 32'h0,   0, 32'h0,  0, R);
    cyc("release",     1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));
    cyc("idle_nordy",  1, 0, 0, 0, 32'h0,   0, 32'h0,  0, mk(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));
    // Load-use stall, two frozen cycles
    cyc("ld_use",      1, 1, 1, 0, 32'h0,   0, 32'h0,  0, mk(0, 0, 32'h0, 0, 0, 1, 32'h0, 0, 0, 0));
    cyc("stall",       1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(0, 0, 32'h0, 0, 0, 1, 32'h0, 0, 0, 0));
    cyc("stall_done",  1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));
    // Taken branch and flush window
    cyc("br40",        1, 1, 0, 1, 32'h40,  0, 32'h0,  0, mk(1, 1, 32'h40, 0, 1, 0, 32'h0, 0, 0, 0));
    cyc("flush_ld_ign",1, 1, 1, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0));
    cyc("flush_done",  1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));
    cyc("br8_nordy",   1, 0, 0, 1, 32'h8,   0, 32'h0,  0, mk(1, 1, 32'h8, 0, 1, 0, 32'h0, 0, 0, 0));
    cyc("flush_nordy", 1, 0, 0, 0, 32'h0,   0, 32'h0,  0, mk(0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0));
    cyc("run",         1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));
    // Exception beats branch; nested exception dropped; eret returns
    cyc("exc_vs_br",   1, 1, 0, 1, 32'h80,  1, 32'h24, 0, mk(1, 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0));
    cyc("exc_flush",   1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h24, 1, 0, 0));
    cyc("handler_run", 1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h24, 1, 0, 0));
    cyc("exc_nested",  1, 1, 0, 0, 32'h0,   1, 32'h99, 0, mk(1, 0, 32'h0, 0, 0, 0, 32'h24, 1, 1, 0));
    cyc("nested_br",   1, 1, 0, 1, 32'h50,  1, 32'h99, 0, mk(1, 1, 32'h50, 0, 1, 0, 32'h24, 1, 1, 0));
    cyc("eret_in_fl",  1, 1, 0, 0, 32'h0,   0, 32'h0,  1, mk(1, 1, 32'h24, 0, 1, 0, 32'h24, 1, 0, 0));
    cyc("eret_flush",  1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("post_eret",   1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h24, 0, 0, 0));
    // Branch preempts a stall while ld_use stays high
    cyc("ld_hold",     1, 1, 1, 0, 32'h0,   0, 32'h0,  0, mk(0, 0, 32'h0, 0, 0, 1, 32'h24, 0, 0, 0));
    cyc("br_in_stall", 1, 1, 1, 1, 32'h100, 0, 32'h0,  0, mk(1, 1, 32'h100, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("fl_aft_stall",1, 1, 1, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("run_again",   1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h24, 0, 0, 0));
    // eret outside a handler still jumps to epc
    cyc("eret_nohand", 1, 1, 0, 0, 32'h0,   0, 32'h0,  1, mk(1, 1, 32'h24, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("eret_nh_fl",  1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("run2",        1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h24, 0, 0, 0));
    // Misaligned branch target
`ifdef PC_ALIGN_CHK_EN
    cyc("br_misalign", 1, 1, 0, 1, 32'h42,  0, 32'h0,  0, mk(1, 0, 32'h0, 1, 1, 0, 32'h24, 0, 0, 1));
    cyc("mis_flush",   1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h42, 1, 0, 0));
    cyc("mis_in_hand", 1, 1, 0, 1, 32'h42,  0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h42, 1, 1, 0));
    cyc("mis_eret",    1, 1, 0, 0, 32'h0,   0, 32'h0,  1, mk(1, 1, 32'h42, 0, 1, 0, 32'h42, 1, 0, 0));
    cyc("mis_eret_fl", 1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h42, 0, 0, 0));
`else
    cyc("br_misalign", 1, 1, 0, 1, 32'h42,  0, 32'h0,  0, mk(1, 1, 32'h42, 0, 1, 0, 32'h24, 0, 0, 0));
    cyc("mis_flush",   1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 1, 0, 32'h24, 0, 0, 0));
`endif
    // Asynchronous reset mid-run clears epc and handler state immediately
    cyc("async_rst",   0, 1, 0, 0, 32'h0,   0, 32'h0,  0, R);
    cyc("rst_release", 1, 1, 0, 0, 32'h0,   0, 32'h0,  0, mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d vectors unchecked, required 0", q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
